// File: rtl/operand_fetch_stage.sv
// ID->EX operand fetch stage: drives bank read addresses, forwards MEM/WB results,
// stalls on load-use and EX-resident dependences, and registers the EX-facing bundle.
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_reg_wr,
  input  logic              in_is_load,
  output logic [AW-1:0]     dir_a,
  output logic [AW-1:0]     dir_b,
  input  logic [XLEN-1:0]   doa,
  input  logic [XLEN-1:0]   dob,
  input  logic              mem_reg_wr,
  input  logic              mem_is_load,
  input  logic [AW-1:0]     mem_dir,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_reg_wr,
  input  logic [AW-1:0]     wb_dir,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op_a,
  output logic [XLEN-1:0]   out_op_b,
  output logic [XLEN-1:0]   out_imm,
  output logic [AW-1:0]     out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_reg_wr,
  output logic              out_is_load,
  output logic              hazard_stall
);

  logic              r_valid;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_op_b;
  logic [XLEN-1:0]   r_imm;
  logic [AW-1:0]     r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_reg_wr;
  logic              r_is_load;

  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_op_b;
  logic              w_haz_a;
  logic              w_haz_b;
  logic              w_stall;
  logic              w_ready;
  logic              w_capture;

  // MEM beats WB: it is the younger result. WB forwarding covers the same-edge bank write.
  function automatic logic [XLEN-1:0] f_select(input logic [AW-1:0]   s,
                                               input logic [XLEN-1:0] bank);
    if (s == '0)
      return '0;
    else if (mem_reg_wr && (mem_dir == s))
      return mem_data;
    else if (wb_reg_wr && (wb_dir == s))
      return wb_data;
    else
      return bank;
  endfunction

  function automatic logic f_hazard(input logic [AW-1:0] s);
    return (s != '0) &&
           ((r_valid && r_reg_wr && (r_rd == s)) ||
            (mem_reg_wr && mem_is_load && (mem_dir == s)));
  endfunction

  always_comb begin
    w_op_a    = f_select(in_rs1, doa);
    w_op_b    = f_select(in_rs2, dob);
    w_haz_a   = f_hazard(in_rs1);
    w_haz_b   = f_hazard(in_rs2);
    w_stall   = in_valid && (w_haz_a || w_haz_b);
    w_ready   = !w_stall && !flush && (!r_valid || out_ready);
    w_capture = in_valid && w_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_reg_wr  <= 1'b0;
      r_is_load <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
      r_imm     <= in_imm;
      r_rd      <= in_rd;
      r_ctrl    <= in_ctrl;
      r_reg_wr  <= in_reg_wr;
      r_is_load <= in_is_load;
    end else if (out_ready || !r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign dir_a        = in_rs1;
  assign dir_b        = in_rs2;
  assign in_ready     = w_ready;
  assign hazard_stall = w_stall;
  assign out_valid    = r_valid;
  assign out_op_a     = r_op_a;
  assign out_op_b     = r_op_b;
  assign out_imm      = r_imm;
  assign out_rd       = r_rd;
  assign out_ctrl     = r_ctrl;
  assign out_reg_wr   = r_reg_wr;
  assign out_is_load  = r_is_load;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding priority, hazard stalls,
// backpressure, flush and asynchronous reset, checked with immediate assertions.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic [7:0]  in_ctrl;
  logic        in_reg_wr, in_is_load;
  logic [4:0]  dir_a, dir_b;
  logic [31:0] doa, dob;
  logic        mem_reg_wr, mem_is_load;
  logic [4:0]  mem_dir;
  logic [31:0] mem_data;
  logic        wb_reg_wr;
  logic [4:0]  wb_dir;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_imm;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic        out_reg_wr, out_is_load, hazard_stall;

  int n_tests = 0;
  int n_fail  = 0;

  operand_fetch_stage #(.XLEN(32), .AW(5), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .in_reg_wr(in_reg_wr), .in_is_load(in_is_load),
    .dir_a(dir_a), .dir_b(dir_b), .doa(doa), .dob(dob),
    .mem_reg_wr(mem_reg_wr), .mem_is_load(mem_is_load), .mem_dir(mem_dir),
    .mem_data(mem_data), .wb_reg_wr(wb_reg_wr), .wb_dir(wb_dir), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .out_reg_wr(out_reg_wr),
    .out_is_load(out_is_load), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_imm = 0; in_ctrl = 0; in_reg_wr = 0; in_is_load = 0;
    doa = 0; dob = 0; mem_reg_wr = 0; mem_is_load = 0; mem_dir = 0;
    mem_data = 0; wb_reg_wr = 0; wb_dir = 0; wb_data = 0; out_ready = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_a", out_op_a, 32'd0);
    chk("rst_op_b", out_op_b, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    rst_n = 1;
    tick();

    // 1: plain bank read
    in_valid = 1; in_rs1 = 3; in_rs2 = 4; in_rd = 1; in_imm = 32'h1234;
    in_ctrl = 8'h5A; doa = 32'h11; dob = 32'h22;
    #1;
    chk("t1_dir_a", {27'd0, dir_a}, 32'd3);
    chk("t1_dir_b", {27'd0, dir_b}, 32'd4);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_op_a", out_op_a, 32'h11);
    chk("t1_op_b", out_op_b, 32'h22);
    chk("t1_imm", out_imm, 32'h1234);
    chk("t1_ctrl", {24'd0, out_ctrl}, 32'h5A);
    chk("t1_rd", {27'd0, out_rd}, 32'd1);

    // 2: WB forward, then MEM wins over WB
    in_rs1 = 5; in_rs2 = 0; doa = 0; wb_reg_wr = 1; wb_dir = 5; wb_data = 32'hAA;
    tick();
    chk("t2_wb_fwd", out_op_a, 32'hAA);
    mem_reg_wr = 1; mem_dir = 5; mem_data = 32'hBB;
    tick();
    chk("t2_mem_prio", out_op_a, 32'hBB);

    // 3: x0 always reads zero
    mem_reg_wr = 0; in_rs1 = 0; wb_dir = 0; wb_data = 32'hFF; doa = 32'h33;
    tick();
    chk("t3_x0", out_op_a, 32'd0);

    // 4: EX-resident rd=7 stalls rs2=7 for one bubble, then MEM forward
    wb_reg_wr = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 7; in_reg_wr = 1;
    tick();
    chk("t4_ex_rd", {27'd0, out_rd}, 32'd7);
    chk("t4_ex_wr", {31'd0, out_reg_wr}, 32'd1);
    in_rs2 = 7; in_rd = 2; in_reg_wr = 0;
    #1;
    chk("t4_stall", {31'd0, hazard_stall}, 32'd1);
    chk("t4_not_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t4_bubble", {31'd0, out_valid}, 32'd0);
    chk("t4_bubble_hold", {27'd0, out_rd}, 32'd7);
    chk("t4_stall_clr", {31'd0, hazard_stall}, 32'd0);
    mem_reg_wr = 1; mem_dir = 7; mem_data = 32'h77; dob = 0;
    tick();
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_op_b", out_op_b, 32'h77);

    // 5: load in MEM stalls rs1=9, then forwards from WB
    in_rs1 = 9; in_rs2 = 0; mem_is_load = 1; mem_dir = 9; mem_data = 32'hDEAD;
    #1;
    chk("t5_stall", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("t5_bubble", {31'd0, out_valid}, 32'd0);
    mem_reg_wr = 0; mem_is_load = 0; wb_reg_wr = 1; wb_dir = 9; wb_data = 32'h99; doa = 32'h5;
    #1;
    chk("t5_stall_clr", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("t5_op_a", out_op_a, 32'h99);

    // 6: backpressure, flush, async reset
    wb_reg_wr = 0; in_rs1 = 3; doa = 32'h44; in_rd = 4; in_reg_wr = 1;
    tick();
    chk("t6_cap", out_op_a, 32'h44);
    out_ready = 0; in_rs1 = 1; in_rs2 = 2; in_reg_wr = 0; doa = 32'h99;
    mem_reg_wr = 1; wb_reg_wr = 1;
    for (int i = 0; i < 3; i++) begin
      mem_dir = 4; mem_data = 32'h100 + i; wb_dir = 4; wb_data = 32'h200 + i;
      #1;
      chk("t6_hold_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t6_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_hold_op_a", out_op_a, 32'h44);
    end
    mem_reg_wr = 0; wb_reg_wr = 0;
    in_valid = 0; in_rs2 = 4;
    #1;
    chk("t6_noinvalid_stall", {31'd0, hazard_stall}, 32'd0);
    in_valid = 1; in_rs2 = 2; flush = 1;
    #1;
    chk("t6_flush_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t6_flush", {31'd0, out_valid}, 32'd0);
    flush = 0; out_ready = 1; in_rs1 = 6; in_rs2 = 0; doa = 32'h66;
    tick();
    chk("t6_recap", out_op_a, 32'h66);
    #2;
    rst_n = 0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_op_a", out_op_a, 32'd0);
    idle();
    #10;
    rst_n = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
